// File: rtl/sdram_rd_burst_pkg.sv
// sdram_rd_burst_pkg: SDRAM command codes, timing defaults, address field split and read FSM states
package sdram_rd_burst_pkg;

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    localparam int TRCD_DEF = 2;
    localparam int CAS_DEF  = 3;
    localparam int TRP_DEF  = 2;

    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_ACTIVE = 8'b0000_0010,
        S_TRCD   = 8'b0000_0100,
        S_READ   = 8'b0000_1000,
        S_RDDATA = 8'b0001_0000,
        S_PRE    = 8'b0010_0000,
        S_TRP    = 8'b0100_0000,
        S_END    = 8'b1000_0000
    } state_t;

    function automatic logic [1:0] addr_bank(input logic [20:0] a);
        return a[20:19];
    endfunction

    function automatic logic [10:0] addr_row(input logic [20:0] a);
        return a[18:8];
    endfunction

    function automatic logic [7:0] addr_col(input logic [20:0] a);
        return a[7:0];
    endfunction

endpackage

// File: rtl/sdram_rd_burst.sv
// sdram_rd_burst: full-page SDRAM read engine issuing ACTIVE/READ/BURST STOP/PRECHARGE and capturing data
module sdram_rd_burst
    import sdram_rd_burst_pkg::*;
#(
    parameter int TRCD_CLK = TRCD_DEF,
    parameter int CAS_LAT  = CAS_DEF,
    parameter int TRP_CLK  = TRP_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [20:0] rd_addr_in,
    input  logic [8:0]  rd_burst_len,
    input  logic [31:0] sdram_data_in,
    input  logic        rd_fifo_req,
    output logic        rd_req,
    output logic        rd_end,
    output logic [3:0]  rd_cmd,
    output logic [1:0]  rd_ba,
    output logic [10:0] rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_sdram_data
);

    localparam logic [8:0] TRCD_LAST = 9'(TRCD_CLK - 2);
    localparam logic [8:0] TRP_LAST  = 9'(TRP_CLK - 2);
    localparam logic [8:0] CAS_M1    = 9'(CAS_LAT - 1);
    localparam logic [8:0] CAS_M2    = 9'(CAS_LAT - 2);

    state_t      state, next_state;
    logic [8:0]  cnt, len, len_in;
    logic [20:0] addr_q;
    logic        end_d, sample;

    assign len_in = rd_burst_len == 9'd0 ? 9'd1 : (rd_burst_len > 9'd256 ? 9'd256 : rd_burst_len);
    assign rd_req = rd_fifo_req & init_end & (state == S_IDLE);

    // next-state and command decode from state and the per-state cycle counter
    always_comb begin
        next_state = state;
        rd_cmd     = CMD_NOP;
        rd_ba      = 2'b11;
        rd_addr    = 11'h7ff;
        sample     = 1'b0;
        case (state)
            S_IDLE:   if (init_end && rd_en && !end_d) next_state = S_ACTIVE;
            S_ACTIVE: begin
                rd_cmd     = CMD_ACTIVE;
                rd_ba      = addr_bank(addr_q);
                rd_addr    = addr_row(addr_q);
                next_state = TRCD_CLK > 1 ? S_TRCD : S_READ;
            end
            S_TRCD:   if (cnt == TRCD_LAST) next_state = S_READ;
            S_READ:   begin
                rd_cmd     = CMD_READ;
                rd_ba      = addr_bank(addr_q);
                rd_addr    = {3'b000, addr_col(addr_q)};
                next_state = S_RDDATA;
            end
            S_RDDATA: begin
                if (cnt == len - 9'd1 && len != 9'd256) rd_cmd = CMD_BURST_STOP;
                sample = cnt >= CAS_M1;
                if (cnt == len + CAS_M2) next_state = S_PRE;
            end
            S_PRE:    begin
                rd_cmd     = CMD_PRECHARGE;
                rd_addr    = 11'h400;
                next_state = TRP_CLK > 1 ? S_TRP : S_END;
            end
            S_TRP:    if (cnt == TRP_LAST) next_state = S_END;
            S_END:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // state, counter, request latch, and registered strobes / captured data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            len           <= 9'd1;
            addr_q        <= '0;
            end_d         <= 1'b0;
            rd_end        <= 1'b0;
            rd_ack        <= 1'b0;
            rd_sdram_data <= '0;
        end else begin
            state  <= next_state;
            cnt    <= next_state != state ? 9'd0 : cnt + 9'd1;
            end_d  <= state == S_END;
            rd_end <= next_state == S_END;
            rd_ack <= sample;
            if (state == S_IDLE && next_state == S_ACTIVE) begin
                addr_q <= rd_addr_in;
                len    <= len_in;
            end
            if (sample) rd_sdram_data <= sdram_data_in;
        end
    end

endmodule
